// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared CDB lane type and default arbiter sizing
package rv32i_types;

    localparam int NUM_REQ_DEF  = 4;
    localparam int CDB_SIZE_DEF = 2;
    // Widest ROB tag a lane can carry; narrower tags are zero-extended.
    localparam int ROB_W_MAX    = 8;

    typedef struct packed {
        logic                 valid;
        logic [ROB_W_MAX-1:0] rob;
        logic [31:0]          rd_v;
    } cdb_lane_t;

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// rtl/cdb_arbiter_rr_picker.sv - rotating pick of up to CDB_SIZE requesters starting at ptr
module rr_picker
    import rv32i_types::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DEF,
    parameter int CDB_SIZE = CDB_SIZE_DEF,
    parameter int PW       = 2
) (
    input  logic [NUM_REQ-1:0]  valid,
    input  logic [PW-1:0]       ptr,
    output logic [NUM_REQ-1:0]  grant,
    output logic [PW-1:0]       lane_idx [CDB_SIZE],
    output logic [CDB_SIZE-1:0] lane_vld,
    output logic [PW-1:0]       next_ptr
);

    localparam int CW = $clog2(CDB_SIZE + 1);

    // Walk requesters from ptr with wraparound; the k-th hit is steered to lane k.
    always_comb begin
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        logic [PW-1:0] last;
        logic [CW-1:0] cnt;
        grant    = '0;
        lane_vld = '0;
        for (int k = 0; k < CDB_SIZE; k++) lane_idx[k] = '0;
        cnt  = '0;
        last = ptr;
        sum  = '0;
        idx  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            sum = {1'b0, ptr} + (PW+1)'(j);
            if (sum >= (PW+1)'(NUM_REQ)) sum = sum - (PW+1)'(NUM_REQ);
            idx = sum[PW-1:0];
            if (valid[idx] && (cnt < CW'(CDB_SIZE))) begin
                grant[idx] = 1'b1;
                for (int k = 0; k < CDB_SIZE; k++) begin
                    if (cnt == CW'(k)) begin
                        lane_idx[k] = idx;
                        lane_vld[k] = 1'b1;
                    end
                end
                cnt  = cnt + 1'b1;
                last = idx;
            end
        end
        next_ptr = (last == PW'(NUM_REQ - 1)) ? '0 : last + 1'b1;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin CDB arbiter; CDB_ARB_PERF_EN adds per-requester grant counters
module cdb_arbiter
    import rv32i_types::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int CDB_SIZE  = CDB_SIZE_DEF,
    parameter int ROB_DEPTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [ROB_DEPTH-1:0] req_rob   [NUM_REQ],
    input  logic [31:0]          req_data  [NUM_REQ],
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [CDB_SIZE-1:0]  cdb_valid,
    output logic [ROB_DEPTH-1:0] cdb_rob   [CDB_SIZE],
    output logic [31:0]          cdb_rd_v  [CDB_SIZE]
`ifdef CDB_ARB_PERF_EN
    ,
    output logic [31:0]          perf_grant_cnt [NUM_REQ]
`endif
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]  pick_grant;
    logic [PW-1:0]       lane_idx [CDB_SIZE];
    logic [CDB_SIZE-1:0] lane_vld;
    logic [PW-1:0]       next_ptr;
    logic                arb_en;
    cdb_lane_t           lane_q [CDB_SIZE];
    cdb_lane_t           lane_d [CDB_SIZE];

    rr_picker #(
        .NUM_REQ  (NUM_REQ),
        .CDB_SIZE (CDB_SIZE),
        .PW       (PW)
    ) u_picker (
        .valid    (req_valid),
        .ptr      (rr_ptr_q),
        .grant    (pick_grant),
        .lane_idx (lane_idx),
        .lane_vld (lane_vld),
        .next_ptr (next_ptr)
    );

    // Grants are suppressed during reset and flush so nothing is popped that will not be broadcast.
    assign arb_en    = rst & ~flush;
    assign req_ready = arb_en ? pick_grant : '0;

    // Next lane contents and pointer; idle lanes keep stale tag/data with valid low.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (arb_en && (|pick_grant)) rr_ptr_d = next_ptr;
        for (int k = 0; k < CDB_SIZE; k++) begin
            lane_d[k]       = lane_q[k];
            lane_d[k].valid = 1'b0;
            if (arb_en && lane_vld[k]) begin
                lane_d[k].valid = 1'b1;
                lane_d[k].rob   = ROB_W_MAX'(req_rob[lane_idx[k]]);
                lane_d[k].rd_v  = req_data[lane_idx[k]];
            end
        end
    end

    // Lane and pointer registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q <= '0;
            for (int k = 0; k < CDB_SIZE; k++) lane_q[k] <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int k = 0; k < CDB_SIZE; k++) lane_q[k] <= lane_d[k];
        end
    end

    // Unpack lane registers onto the broadcast ports.
    always_comb begin
        for (int k = 0; k < CDB_SIZE; k++) begin
            cdb_valid[k] = lane_q[k].valid;
            cdb_rob[k]   = lane_q[k].rob[ROB_DEPTH-1:0];
            cdb_rd_v[k]  = lane_q[k].rd_v;
        end
    end

`ifdef CDB_ARB_PERF_EN
    logic [31:0] perf_q [NUM_REQ];

    // Saturating count of transfers per requester.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) perf_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i] && (perf_q[i] != '1)) perf_q[i] <= perf_q[i] + 1'b1;
            end
        end
    end

    assign perf_grant_cnt = perf_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed and random checks of cdb_arbiter against a queue-based model
module tb_cdb_arbiter;

    localparam int N = 4;
    localparam int C = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [3:0]  req_valid;
    logic [2:0]  req_rob  [N];
    logic [31:0] req_data [N];
    logic [3:0]  req_ready;
    logic [1:0]  cdb_valid;
    logic [2:0]  cdb_rob  [C];
    logic [31:0] cdb_rd_v [C];
`ifdef CDB_ARB_PERF_EN
    logic [31:0] perf_grant_cnt [N];
`endif

    int          vectors = 0;
    int          miscompares = 0;
    int          mptr = 0;
    int          mcnt [N];
    logic [3:0]  mgrant;
    logic [1:0]  ev;
    logic [2:0]  erob  [C];
    logic [31:0] edata [C];

    always #5 clk = ~clk;

    cdb_arbiter #(.NUM_REQ(N), .CDB_SIZE(C), .ROB_DEPTH(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_rob   (req_rob),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cdb_valid (cdb_valid),
        .cdb_rob   (cdb_rob),
        .cdb_rd_v  (cdb_rd_v)
`ifdef CDB_ARB_PERF_EN
        ,
        .perf_grant_cnt (perf_grant_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check grants against the model, then the broadcast one cycle later.
    task automatic step();
        int q[$];
        #1;
        mgrant = '0;
        if (!flush) begin
            for (int j = 0; j < N; j++) begin
                int idx;
                idx = (mptr + j) % N;
                if (req_valid[idx] && q.size() < C) begin
                    q.push_back(idx);
                    mgrant[idx] = 1'b1;
                end
            end
        end
        chk("req_ready", 32'(req_ready), 32'(mgrant));
        for (int k = 0; k < C; k++) begin
            ev[k] = (k < q.size());
            if (k < q.size()) begin
                erob[k]  = req_rob[q[k]];
                edata[k] = req_data[q[k]];
                mcnt[q[k]]++;
            end
        end
        if (q.size() > 0) mptr = (q[q.size()-1] + 1) % N;
        @(posedge clk);
        @(negedge clk);
        chk("cdb_valid", 32'(cdb_valid), 32'(ev));
        for (int k = 0; k < C; k++) begin
            if (ev[k]) begin
                chk("cdb_rob", 32'(cdb_rob[k]), 32'(erob[k]));
                chk("cdb_rd_v", cdb_rd_v[k], edata[k]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            mcnt[i]     = 0;
            req_rob[i]  = 3'(i + 1);
            req_data[i] = 32'hA000_0000 + 32'(i);
        end
        rst       = 1'b0;
        flush     = 1'b0;
        req_valid = 4'b1111;

        // Reset state, with requests pending
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_cdb_valid", 32'(cdb_valid), 32'h0);
        chk("rst_cdb_rob0", 32'(cdb_rob[0]), 32'h0);
        chk("rst_cdb_rd_v1", cdb_rd_v[1], 32'h0);
        rst = 1'b1;

        // All four valid from ptr 0: grants 0 and 1
        step();
        chk("dir1_ready", 32'(mgrant), 32'h3);
        chk("dir1_lane0", cdb_rd_v[0], 32'hA000_0000);
        chk("dir1_lane1", cdb_rd_v[1], 32'hA000_0001);

        // Remaining two: grants 2 and 3
        req_valid = 4'b1100;
        step();
        chk("dir2_lane0", cdb_rd_v[0], 32'hA000_0002);
        chk("dir2_lane1", cdb_rd_v[1], 32'hA000_0003);

        // Lone requester 3
        req_valid   = 4'b1000;
        req_rob[3]  = 3'd5;
        req_data[3] = 32'hDEAD_BEEF;
        step();
        chk("dir3_valid", 32'(cdb_valid), 32'h1);
        chk("dir3_rob", 32'(cdb_rob[0]), 32'h5);
        chk("dir3_data", cdb_rd_v[0], 32'hDEAD_BEEF);

        // Pointer wrapped to 0
        req_valid = 4'b1111;
        step();
        chk("dir4_lane0", cdb_rd_v[0], 32'hA000_0000);

        // Flush with 0110 pending, then the same requests from ptr 2
        req_valid = 4'b0110;
        flush     = 1'b1;
        step();
        chk("flush_valid", 32'(cdb_valid), 32'h0);
        flush = 1'b0;
        step();
        chk("postflush_lane0", cdb_rd_v[0], 32'hA000_0002);
        chk("postflush_lane1", cdb_rd_v[1], 32'hA000_0001);

        // Random traffic; requesters hold until granted
        req_valid = 4'b0000;
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(1, 0) == 1) begin
                    req_valid[i] = 1'b1;
                    req_rob[i]   = 3'($urandom);
                    req_data[i]  = $urandom;
                end
            end
            flush = ($urandom_range(9, 0) == 0);
            step();
            req_valid = req_valid & ~mgrant;
        end
        flush = 1'b0;

        // Reset mid-cycle while both lanes are valid
        req_valid = 4'b1111;
        step();
        chk("prerst_valid", 32'(cdb_valid), 32'h3);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_valid", 32'(cdb_valid), 32'h0);
        chk("midrst_ready", 32'(req_ready), 32'h0);
        mptr = 0;
        for (int i = 0; i < N; i++) mcnt[i] = 0;
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("postrst_lane0", cdb_rd_v[0], req_data[0]);

`ifdef CDB_ARB_PERF_EN
        for (int i = 0; i < N; i++) mcnt[i] = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        mptr = 0;
        req_valid = 4'b0010;
        repeat (10) step();
        chk("perf_req1", perf_grant_cnt[1], 32'd10);
        for (int i = 0; i < N; i++) chk("perf_cnt", perf_grant_cnt[i], 32'(mcnt[i]));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
